// File: rtl/ml_nn_seq.sv
// ml_nn_seq: sequential signed fixed-point NxN matrix multiplier C = A x B.
// A/B arrive one element pair per beat, a single shared MAC walks i,j,p with
// p innermost, and C is streamed out row-major with a last marker.
module ml_nn_seq #(
    parameter int N    = 2,
    parameter int DW   = 24,
    parameter int FRAC = 15,
    parameter int RND  = 0,
    parameter int SAT  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_a,
    input  logic signed [DW-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_c,
    output logic                 out_last,
    output logic                 busy,
    output logic                 ovf
);
    localparam int NN = N * N;
    localparam int KW = $clog2(NN);
    localparam int IW = $clog2(N);
    localparam int PW = 2 * DW;
    // Wide enough that N scaled products never overflow the accumulator
    localparam int AW = 2 * DW - FRAC + $clog2(N) + 1;
    localparam logic signed [PW-1:0] RND_ADD = (RND != 0) ? (PW'(1) << (FRAC - 1)) : '0;
    localparam logic signed [AW-1:0] C_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] C_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [KW-1:0] K_LAST = KW'(NN - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

    // Optional half-up rounding, then arithmetic shift into accumulator scale
    function automatic logic signed [AW-1:0] scale_prod(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] t;
        t = (p + RND_ADD) >>> FRAC;
        return AW'(t);
    endfunction

    function automatic logic out_of_range(input logic signed [AW-1:0] v);
        return (v > C_MAX) || (v < C_MIN);
    endfunction

    // Clamp (SAT) or wrap to the element width
    function automatic logic signed [DW-1:0] fit(input logic signed [AW-1:0] v);
        if (SAT != 0 && v > C_MAX) return {1'b0, {(DW-1){1'b1}}};
        if (SAT != 0 && v < C_MIN) return {1'b1, {(DW-1){1'b0}}};
        return v[DW-1:0];
    endfunction

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;
    logic                  wb_q, wb_d;
    logic                  c_we_q, c_we_d;
    logic signed [DW-1:0]  out_c_q, out_c_d;
    logic [KW-1:0]         k_q, k_d;
    logic [IW-1:0]         i_q, i_d, j_q, j_d, p_q, p_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [DW-1:0]  c_wdat_q, c_wdat_d;
    logic [KW-1:0]         c_widx_q, c_widx_d;

    logic signed [DW-1:0]  a_mem [NN];
    logic signed [DW-1:0]  b_mem [NN];
    logic signed [DW-1:0]  c_mem [NN];

    logic                  beat, out_hs;
    logic signed [DW-1:0]  a_sel, b_sel;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  sum;
    logic [KW-1:0]         k_nx;

    assign beat   = in_valid && in_ready_q;
    assign out_hs = out_valid_q && out_ready;

    // Shared MAC: operand fetch, full-width product, scaled accumulate
    always_comb begin
        a_sel = a_mem[KW'(int'(i_q) * N + int'(p_q))];
        b_sel = b_mem[KW'(int'(p_q) * N + int'(j_q))];
        prod  = PW'(a_sel) * PW'(b_sel);
        sum   = acc_q + scale_prod(prod);
        k_nx  = k_q + KW'(1);
    end

    // Sequencer: load beats, N^3 MAC cycles plus writeback, then stream C
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_c_d     = out_c_q;
        busy_d      = busy_q;
        ovf_d       = ovf_q;
        wb_d        = wb_q;
        c_we_d      = 1'b0;
        k_d         = k_q;
        i_d         = i_q;
        j_d         = j_q;
        p_d         = p_q;
        acc_d       = acc_q;
        c_wdat_d    = c_wdat_q;
        c_widx_d    = c_widx_q;
        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    state_d = S_LOAD;
                    k_d     = KW'(1);
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    if (k_q == K_LAST) begin
                        state_d    = S_CALC;
                        in_ready_d = 1'b0;
                        k_d        = '0;
                        i_d        = '0;
                        j_d        = '0;
                        p_d        = '0;
                        acc_d      = '0;
                        wb_d       = 1'b0;
                    end else begin
                        k_d = k_nx;
                    end
                end
            end
            S_CALC: begin
                if (!wb_q) begin
                    if (p_q == I_LAST) begin
                        c_we_d   = 1'b1;
                        c_wdat_d = fit(sum);
                        c_widx_d = KW'(int'(i_q) * N + int'(j_q));
                        ovf_d    = ovf_q | out_of_range(sum);
                        acc_d    = '0;
                        p_d      = '0;
                        if (j_q == I_LAST) begin
                            j_d = '0;
                            if (i_q == I_LAST) wb_d = 1'b1;
                            else i_d = i_q + IW'(1);
                        end else begin
                            j_d = j_q + IW'(1);
                        end
                    end else begin
                        acc_d = sum;
                        p_d   = p_q + IW'(1);
                    end
                end else begin
                    // Last element is being written now; element 0 is long settled
                    wb_d        = 1'b0;
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                    out_c_d     = c_mem[KW'(0)];
                    out_last_d  = 1'b0;
                    k_d         = '0;
                end
            end
            S_OUT: begin
                if (out_hs) begin
                    if (out_last_q) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b0;
                        k_d         = '0;
                    end else begin
                        k_d        = k_nx;
                        out_c_d    = c_mem[k_nx];
                        out_last_d = (k_nx == K_LAST);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers, cleared by asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_c_q     <= '0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            wb_q        <= 1'b0;
            c_we_q      <= 1'b0;
            k_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            p_q         <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_c_q     <= out_c_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            wb_q        <= wb_d;
            c_we_q      <= c_we_d;
            k_q         <= k_d;
            i_q         <= i_d;
            j_q         <= j_d;
            p_q         <= p_d;
        end
    end

    // Matrix buffers and accumulator datapath; contents need no reset
    always_ff @(posedge clk) begin
        if (beat) begin
            a_mem[k_q] <= in_a;
            b_mem[k_q] <= in_b;
        end
        if (c_we_q) c_mem[c_widx_q] <= c_wdat_q;
        acc_q    <= acc_d;
        c_wdat_q <= c_wdat_d;
        c_widx_q <= c_widx_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_c     = out_c_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_ml_nn_seq.sv
// Directed bench for ml_nn_seq: two N=2 instances (truncate/wrap and
// round/saturate) driven in lockstep from a vector table, plus an N=4
// instance exercised with gaps, back-pressure and a reset mid-computation.
module tb_ml_nn_seq;
    typedef logic [3:0][23:0] m4_t;
    typedef struct packed {
        m4_t        a, b, c0, c1;
        logic       ovf0, ovf1;
        logic [1:0] mode;
        logic       junk;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
    logic [23:0] in_a2 = '0, in_b2 = '0;
    logic        rdyA, vA, lastA, busyA, ovfA;
    logic        rdyB, vB, lastB, busyB, ovfB;
    logic [23:0] cA, cB;

    logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
    logic [23:0] in_a4 = '0, in_b4 = '0;
    logic        rdyC, vC, lastC, busyC, ovfC;
    logic [23:0] cC;

    int total = 0;
    int bad = 0;

    ml_nn_seq #(.N(2), .DW(24), .FRAC(15), .RND(0), .SAT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(rdyA),
        .in_a(in_a2), .in_b(in_b2), .out_valid(vA), .out_ready(out_ready2),
        .out_c(cA), .out_last(lastA), .busy(busyA), .ovf(ovfA));

    ml_nn_seq #(.N(2), .DW(24), .FRAC(15), .RND(1), .SAT(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(rdyB),
        .in_a(in_a2), .in_b(in_b2), .out_valid(vB), .out_ready(out_ready2),
        .out_c(cB), .out_last(lastB), .busy(busyB), .ovf(ovfB));

    ml_nn_seq #(.N(4), .DW(24), .FRAC(15), .RND(0), .SAT(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(rdyC),
        .in_a(in_a4), .in_b(in_b4), .out_valid(vC), .out_ready(out_ready4),
        .out_c(cC), .out_last(lastC), .busy(busyC), .ovf(ovfC));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic m4_t pk(input logic [23:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    vec_t vecs [7];

    // One matrix through both N=2 instances
    task automatic run2(input vec_t v, input int vi);
        int k, lat, idx, guard, stall;
        k = 0;
        guard = 0;
        while (k < 4 && guard < 200) begin
            guard++;
            @(negedge clk);
            if (v.mode != 0 && $urandom_range(0, 2) == 0) begin
                in_valid2 = 1'b0;
            end else begin
                in_valid2 = 1'b1;
                in_a2 = v.a[k];
                in_b2 = v.b[k];
                if (rdyA) k++;
            end
        end
        chk($sformatf("v%0d beats", vi), k, 4);
        @(negedge clk);
        if (v.junk) begin
            in_valid2 = 1'b1;
            in_a2 = 24'h5A5A5A;
            in_b2 = 24'hA5A5A5;
        end else begin
            in_valid2 = 1'b0;
        end
        chk($sformatf("v%0d in_ready calc", vi), rdyA, 0);
        chk($sformatf("v%0d busy calc", vi), busyA, 1);
        chk($sformatf("v%0d ovfA cleared", vi), ovfA, 0);
        chk($sformatf("v%0d ovfB cleared", vi), ovfB, 0);
        lat = 0;
        while (!vA && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        chk($sformatf("v%0d latency", vi), lat, 9);
        in_valid2 = 1'b0;
        idx = 0;
        guard = 0;
        stall = 4;
        while (idx < 4 && guard < 100) begin
            guard++;
            chk($sformatf("v%0d validA[%0d]", vi, idx), vA, 1);
            chk($sformatf("v%0d validB[%0d]", vi, idx), vB, 1);
            chk($sformatf("v%0d cA[%0d]", vi, idx), cA, v.c0[idx]);
            chk($sformatf("v%0d cB[%0d]", vi, idx), cB, v.c1[idx]);
            chk($sformatf("v%0d lastA[%0d]", vi, idx), lastA, (idx == 3));
            chk($sformatf("v%0d lastB[%0d]", vi, idx), lastB, (idx == 3));
            case (v.mode)
                2'd0: out_ready2 = 1'b1;
                2'd1: out_ready2 = ($urandom_range(0, 1) == 1);
                default: begin
                    out_ready2 = (stall == 0);
                    if (stall > 0) stall--;
                end
            endcase
            if (out_ready2) idx++;
            @(negedge clk);
        end
        out_ready2 = 1'b0;
        chk($sformatf("v%0d out count", vi), idx, 4);
        chk($sformatf("v%0d validA end", vi), vA, 0);
        chk($sformatf("v%0d validB end", vi), vB, 0);
        chk($sformatf("v%0d in_ready end", vi), rdyA, 1);
        chk($sformatf("v%0d busy end", vi), busyA, 0);
        chk($sformatf("v%0d ovfA", vi), ovfA, v.ovf0);
        chk($sformatf("v%0d ovfB", vi), ovfB, v.ovf1);
    endtask

    logic signed [23:0] ma [16];
    logic signed [23:0] mb [16];
    logic [23:0]        mc [16];
    logic               movf;

    task automatic load4(input int tag);
        int k, guard;
        k = 0;
        guard = 0;
        while (k < 16 && guard < 400) begin
            guard++;
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                in_valid4 = 1'b0;
            end else begin
                in_valid4 = 1'b1;
                in_a4 = ma[k];
                in_b4 = mb[k];
                if (rdyC) k++;
            end
        end
        chk($sformatf("n4 m%0d beats", tag), k, 16);
    endtask

    task automatic model4();
        longint s;
        movf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int p = 0; p < 4; p++)
                    s += (longint'(ma[i*4+p]) * longint'(mb[p*4+j])) >>> 15;
                mc[i*4+j] = s[23:0];
                if (s > 64'sd8388607 || s < -64'sd8388608) movf = 1'b1;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, idx, guard;
        vecs[0] = '{a: pk(24'h008000, 24'h0, 24'h0, 24'h008000),
                    b: pk(24'h010000, 24'h004000, 24'hFF8000, 24'h000123),
                    c0: pk(24'h010000, 24'h004000, 24'hFF8000, 24'h000123),
                    c1: pk(24'h010000, 24'h004000, 24'hFF8000, 24'h000123),
                    ovf0: 1'b0, ovf1: 1'b0, mode: 2'd0, junk: 1'b0};
        vecs[1] = '{a: pk(24'h004000, 24'h004000, 24'h004000, 24'h004000),
                    b: pk(24'h004000, 24'h004000, 24'h004000, 24'h004000),
                    c0: pk(24'h004000, 24'h004000, 24'h004000, 24'h004000),
                    c1: pk(24'h004000, 24'h004000, 24'h004000, 24'h004000),
                    ovf0: 1'b0, ovf1: 1'b0, mode: 2'd1, junk: 1'b1};
        vecs[2] = '{a: pk(24'h008000, 24'h008000, 24'h0, 24'h0),
                    b: pk(24'hFF8000, 24'h004000, 24'h008000, 24'h002000),
                    c0: pk(24'h000000, 24'h006000, 24'h0, 24'h0),
                    c1: pk(24'h000000, 24'h006000, 24'h0, 24'h0),
                    ovf0: 1'b0, ovf1: 1'b0, mode: 2'd2, junk: 1'b0};
        vecs[3] = '{a: pk(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF),
                    b: pk(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF),
                    c0: pk(24'hFFFC00, 24'hFFFC00, 24'hFFFC00, 24'hFFFC00),
                    c1: pk(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF),
                    ovf0: 1'b1, ovf1: 1'b1, mode: 2'd0, junk: 1'b1};
        vecs[4] = '{a: pk(24'h000001, 24'h0, 24'h0, 24'h0),
                    b: pk(24'h004000, 24'h0, 24'h0, 24'h0),
                    c0: pk(24'h000000, 24'h0, 24'h0, 24'h0),
                    c1: pk(24'h000001, 24'h0, 24'h0, 24'h0),
                    ovf0: 1'b0, ovf1: 1'b0, mode: 2'd1, junk: 1'b0};
        vecs[5] = '{a: pk(24'hFFFFFF, 24'h0, 24'h0, 24'h0),
                    b: pk(24'h004000, 24'h0, 24'h0, 24'h0),
                    c0: pk(24'hFFFFFF, 24'h0, 24'h0, 24'h0),
                    c1: pk(24'h000000, 24'h0, 24'h0, 24'h0),
                    ovf0: 1'b0, ovf1: 1'b0, mode: 2'd2, junk: 1'b0};
        vecs[6] = '{a: pk(24'h800000, 24'h800000, 24'h800000, 24'h800000),
                    b: pk(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF),
                    c0: pk(24'h000200, 24'h000200, 24'h000200, 24'h000200),
                    c1: pk(24'h800000, 24'h800000, 24'h800000, 24'h800000),
                    ovf0: 1'b1, ovf1: 1'b1, mode: 2'd0, junk: 1'b0};

        repeat (3) @(negedge clk);
        chk("rst in_ready", rdyA, 1);
        chk("rst out_valid", vA, 0);
        chk("rst out_c", cA, 0);
        chk("rst out_last", lastA, 0);
        chk("rst busy", busyA, 0);
        chk("rst ovf", ovfA, 0);
        chk("rst n4 in_ready", rdyC, 1);
        chk("rst n4 out_valid", vC, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int vi = 0; vi < 7; vi++) begin
            if (vi > 0) begin
                chk($sformatf("v%0d sticky ovfA", vi), ovfA, vecs[vi-1].ovf0);
                chk($sformatf("v%0d sticky ovfB", vi), ovfB, vecs[vi-1].ovf1);
            end
            run2(vecs[vi], vi);
        end

        // N=4: first matrix aborted by reset mid-CALC
        for (int k = 0; k < 16; k++) begin
            ma[k] = 24'($urandom);
            mb[k] = 24'($urandom);
        end
        load4(0);
        @(negedge clk);
        in_valid4 = 1'b0;
        repeat (20) @(negedge clk);
        chk("n4 busy mid calc", busyC, 1);
        rst_n = 1'b0;
        #1;
        chk("n4 abort out_valid", vC, 0);
        chk("n4 abort busy", busyC, 0);
        chk("n4 abort in_ready", rdyC, 1);
        chk("n4 abort out_c", cC, 0);
        chk("abort ovfA", ovfA, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("n4 idle out_valid", vC, 0);

        // N=4: second matrix, checked against the reference model
        for (int k = 0; k < 16; k++) begin
            ma[k] = (k % 3 == 0) ? 24'($urandom) : 24'($urandom_range(0, 24'h01FFFF) - 24'h010000);
            mb[k] = (k % 4 == 1) ? 24'($urandom) : 24'($urandom_range(0, 24'h01FFFF) - 24'h010000);
        end
        model4();
        load4(1);
        @(negedge clk);
        in_valid4 = 1'b0;
        lat = 0;
        while (!vC && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        chk("n4 latency", lat, 65);
        idx = 0;
        guard = 0;
        while (idx < 16 && guard < 400) begin
            guard++;
            chk($sformatf("n4 valid[%0d]", idx), vC, 1);
            chk($sformatf("n4 c[%0d]", idx), cC, mc[idx]);
            chk($sformatf("n4 last[%0d]", idx), lastC, (idx == 15));
            out_ready4 = ($urandom_range(0, 2) != 0);
            if (out_ready4) idx++;
            @(negedge clk);
        end
        out_ready4 = 1'b0;
        chk("n4 out count", idx, 16);
        chk("n4 valid end", vC, 0);
        chk("n4 in_ready end", rdyC, 1);
        chk("n4 ovf", ovfC, movf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
